watch_time_chain: RTL

//   Parametrised successor of the watch datapath: centisecond/second/minute/hour chain with

---
 rtl/watch_time_chain_pkg.sv | 27 ++
 rtl/watch_time_chain_field_counter.sv | 106 ++++++++++
 rtl/watch_time_chain.sv | 100 ++++++++++
 3 files changed

// File: rtl/watch_time_chain_pkg.sv
// rtl/watch_time_chain_pkg.sv - shared definitions for the watch time chain
// Purpose: edit-field select codes, field moduli and the 24h -> 12h hour mapping.
// Ports: none (package).
package watch_time_chain_pkg;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_SEC  = 2'd1,
      SEL_MIN  = 2'd2,
      SEL_HOUR = 2'd3
   } sel_e;

   localparam int SEC_MOD  = 60;
   localparam int MIN_MOD  = 60;
   localparam int HOUR_MOD = 24;

   // 0 -> 12, 13..23 -> 1..11, 1..12 unchanged
   function automatic logic [4:0] hour_to_12h(input logic [4:0] hour);
      if (hour == 5'd0)
         return 5'd12;
      else if (hour > 5'd12)
         return hour - 5'd12;
      else
         return hour;
   endfunction

endpackage

// File: rtl/watch_time_chain_field_counter.sv
// rtl/watch_time_chain_field_counter.sv - one modulo-MOD field of the time chain
// Purpose: counts on incoming carry/borrow, applies up/down edits, keeps a 1-deep
//          pending edit when an edit collides with a carry/borrow, and registers
//          its own carry/borrow out for the next stage.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   carry_in        +1 request from the lower stage
//   borrow_in       -1 request from the lower stage
//   inc, dec        edit pulses (already qualified by field select); both set = ignored
//   clear_pending   drops a stored edit (edit field changed)
//   value           current field value, 0..MOD-1
//   carry_out       registered pulse after a MOD-1 -> 0 wrap
//   borrow_out      registered pulse after a 0 -> MOD-1 wrap
module watch_time_chain_field_counter #(
   parameter int BIT_WIDTH = 6,
   parameter int MOD       = 60,
   parameter int START     = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 carry_in,
   input  logic                 borrow_in,
   input  logic                 inc,
   input  logic                 dec,
   input  logic                 clear_pending,
   output logic [BIT_WIDTH-1:0] value,
   output logic                 carry_out,
   output logic                 borrow_out
);
   import watch_time_chain_pkg::*;

   localparam logic [BIT_WIDTH-1:0] MAX_V   = BIT_WIDTH'(MOD - 1);
   localparam logic [BIT_WIDTH-1:0] START_V = BIT_WIDTH'(START);

   logic                 pending, pending_up;
   logic                 next_pending, next_pending_up;
   logic [BIT_WIDTH-1:0] next_value;
   logic                 next_carry, next_borrow;
   logic                 step_up, step_dn;
   logic                 edit_req, pending_live;

   assign edit_req     = inc ^ dec;
   assign pending_live = pending & ~clear_pending;

   always_comb begin
      step_up         = 1'b0;
      step_dn         = 1'b0;
      next_pending    = pending_live;
      next_pending_up = pending_up;
      if (carry_in || borrow_in) begin
         step_up = carry_in;
         step_dn = ~carry_in;
         // the colliding edit is parked; a second one while parked is lost
         if (edit_req && !pending_live) begin
            next_pending    = 1'b1;
            next_pending_up = inc;
         end
      end else if (pending_live) begin
         // stored edit wins over a fresh one, which is dropped
         step_up      = pending_up;
         step_dn      = ~pending_up;
         next_pending = 1'b0;
      end else if (edit_req) begin
         step_up = inc;
         step_dn = dec;
      end
   end

   always_comb begin
      next_value  = value;
      next_carry  = 1'b0;
      next_borrow = 1'b0;
      if (step_up) begin
         if (value == MAX_V) begin
            next_value = '0;
            next_carry = 1'b1;
         end else begin
            next_value = value + 1'b1;
         end
      end else if (step_dn) begin
         if (value == '0) begin
            next_value  = MAX_V;
            next_borrow = 1'b1;
         end else begin
            next_value = value - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value      <= START_V;
         carry_out  <= 1'b0;
         borrow_out <= 1'b0;
         pending    <= 1'b0;
         pending_up <= 1'b0;
      end else begin
         value      <= next_value;
         carry_out  <= next_carry;
         borrow_out <= next_borrow;
         pending    <= next_pending;
         pending_up <= next_pending_up;
      end
   end

endmodule

// File: rtl/watch_time_chain.sv
// rtl/watch_time_chain.sv - centisecond/second/minute/hour watch datapath
// Purpose: tick divider, four chained field counters with edit support, 12h view.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_run           1: divider and sub-second field advance
//   i_sel           edit field (none/sec/min/hour)
//   i_up, i_down    one-cycle edit pulses on the selected field
//   i_mode_12h      1: o_hour_disp in 12h form
//   o_msec..o_hour  field values (hour always 24h)
//   o_hour_disp     hour for display, o_pm afternoon flag
//   o_day_tick      pulse on hour 23 -> 0, o_day_borrow pulse on hour 0 -> 23
module watch_time_chain #(
   parameter int SYS_CLK_HZ = 100_000_000,
   parameter int TICK_HZ    = 100,
   parameter int MSEC_MOD   = 100,
   parameter int HOUR_START = 12,
   parameter int MIN_START  = 0,
   parameter int SEC_START  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_run,
   input  logic [1:0] i_sel,
   input  logic       i_up,
   input  logic       i_down,
   input  logic       i_mode_12h,
   output logic [6:0] o_msec,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic [4:0] o_hour,
   output logic [4:0] o_hour_disp,
   output logic       o_pm,
   output logic       o_day_tick,
   output logic       o_day_borrow
);
   import watch_time_chain_pkg::*;

   localparam int DIV   = SYS_CLK_HZ / TICK_HZ;
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [1:0]       sel_q;
   logic             sel_chg;
   logic             msec_carry, msec_borrow, sec_carry, sec_borrow, min_carry, min_borrow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         tick    <= 1'b0;
         sel_q   <= 2'd0;
      end else begin
         tick  <= 1'b0;
         sel_q <= i_sel;
         if (i_run) begin
            if (div_cnt == DIV_LAST) begin
               div_cnt <= '0;
               tick    <= 1'b1;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
         end
      end
   end

   assign sel_chg = (i_sel != sel_q);

   // sub-second field: no edits, so its borrow_out stays 0 and just closes the chain
   watch_time_chain_field_counter #(.BIT_WIDTH(7), .MOD(MSEC_MOD), .START(0)) u_msec (
      .clk(clk), .rst(rst), .carry_in(tick), .borrow_in(1'b0),
      .inc(1'b0), .dec(1'b0), .clear_pending(1'b0),
      .value(o_msec), .carry_out(msec_carry), .borrow_out(msec_borrow)
   );

   watch_time_chain_field_counter #(.BIT_WIDTH(6), .MOD(SEC_MOD), .START(SEC_START)) u_sec (
      .clk(clk), .rst(rst), .carry_in(msec_carry), .borrow_in(msec_borrow),
      .inc(i_up & (i_sel == SEL_SEC)), .dec(i_down & (i_sel == SEL_SEC)),
      .clear_pending(sel_chg),
      .value(o_sec), .carry_out(sec_carry), .borrow_out(sec_borrow)
   );

   watch_time_chain_field_counter #(.BIT_WIDTH(6), .MOD(MIN_MOD), .START(MIN_START)) u_min (
      .clk(clk), .rst(rst), .carry_in(sec_carry), .borrow_in(sec_borrow),
      .inc(i_up & (i_sel == SEL_MIN)), .dec(i_down & (i_sel == SEL_MIN)),
      .clear_pending(sel_chg),
      .value(o_min), .carry_out(min_carry), .borrow_out(min_borrow)
   );

   watch_time_chain_field_counter #(.BIT_WIDTH(5), .MOD(HOUR_MOD), .START(HOUR_START)) u_hour (
      .clk(clk), .rst(rst), .carry_in(min_carry), .borrow_in(min_borrow),
      .inc(i_up & (i_sel == SEL_HOUR)), .dec(i_down & (i_sel == SEL_HOUR)),
      .clear_pending(sel_chg),
      .value(o_hour), .carry_out(o_day_tick), .borrow_out(o_day_borrow)
   );

   assign o_pm        = (o_hour >= 5'd12);
   assign o_hour_disp = i_mode_12h ? hour_to_12h(o_hour) : o_hour;

endmodule
